// File: rtl/crc_parallel.sv
// Single-cycle parallel CRC generator with run-time programmable polynomial
// and active width. One FRAME_SIZE-bit word is folded into the CRC register
// per evaluation; the result is combinational in data_in and crc_in, while
// the polynomial and width mask are registered.
module crc_parallel #(
   parameter int CRC_SIZE   = 32,
   parameter int FRAME_SIZE = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [FRAME_SIZE-1:0] data_in,
   input  logic [CRC_SIZE-1:0]   crc_in,
   input  logic [CRC_SIZE-1:0]   crc_poly,
   input  logic [CRC_SIZE-1:0]   crc_poly_size,
   output logic [CRC_SIZE-1:0]   crc_out
);

   logic [CRC_SIZE-1:0] poly_q;
   logic [CRC_SIZE-1:0] mask_q;
   logic [CRC_SIZE-1:0] top_sel;
   logic [CRC_SIZE-1:0] poly_m;
   logic [CRC_SIZE-1:0] r;
   logic                fb;

   // Capture polynomial and width mask every cycle; a cleared mask forces a zero CRC.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         poly_q <= '0;
         mask_q <= '0;
      end else begin
         poly_q <= crc_poly;
         mask_q <= crc_poly_size;
      end
   end

   // One-hot pick of the MSB inside the active width; it is the LFSR feedback tap.
   assign top_sel = mask_q & ~(mask_q >> 1);

   // Polynomial bits above the active width must never reach the register.
   assign poly_m  = poly_q & mask_q;

   // Unrolled LFSR: one shift/feedback step per data bit, MSB of data_in first.
   always_comb begin
      fb = 1'b0;
      r  = crc_in & mask_q;
      for (int i = FRAME_SIZE - 1; i >= 0; i--) begin
         fb = data_in[i] ^ (|(r & top_sel));
         r  = ((r << 1) & mask_q) ^ (poly_m & {CRC_SIZE{fb}});
      end
      crc_out = r;
   end

endmodule

// File: tb/tb_crc_parallel.sv
// Self-checking bench for crc_parallel: polynomial long-division model,
// code-word residue check, and directed literal expectations.
module tb_crc_parallel;

   logic        clk;
   logic        rst_n;
   logic [31:0] data_in;
   logic [31:0] crc_in;
   logic [31:0] crc_poly;
   logic [31:0] crc_poly_size;
   logic [31:0] crc_out;

   crc_parallel #(.CRC_SIZE(32), .FRAME_SIZE(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .data_in       (data_in),
      .crc_in        (crc_in),
      .crc_poly      (crc_poly),
      .crc_poly_size (crc_poly_size),
      .crc_out       (crc_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   logic        chk_on = 1'b0;
   logic        lit_on = 1'b0;
   logic [31:0] lit_exp = 32'd0;
   string       lit_name = "";
   logic [31:0] m_poly = 32'd0;
   logic [31:0] m_mask = 32'd0;
   logic [31:0] exp_crc;
   logic [31:0] res;

   function automatic int width_of(input logic [31:0] m);
      int n;
      n = 0;
      for (int k = 0; k < 32; k++) if (m[k]) n++;
      return n;
   endfunction

   // (seed*x^32 + D*x^n) mod (x^n + poly), by long division over a wide accumulator
   function automatic logic [31:0] model_crc(input logic [31:0] d, input logic [31:0] s,
                                             input logic [31:0] p, input logic [31:0] m);
      int          n;
      logic [95:0] acc;
      logic [95:0] pfull;
      n = width_of(m);
      if (n == 0) return 32'd0;
      acc   = ({64'd0, s & m} << 32) ^ ({64'd0, d} << n);
      pfull = {64'd0, p & m} | (96'd1 << n);
      for (int k = 95; k >= n; k--)
         if (acc[k]) acc = acc ^ (pfull << (k - n));
      return acc[31:0] & m;
   endfunction

   // Bit-serial division remainder of the code word {d, c[n-1:0]}
   function automatic logic [31:0] residue(input logic [31:0] d, input logic [31:0] c,
                                           input logic [31:0] p, input logic [31:0] m);
      int          n;
      logic [31:0] r;
      logic        b;
      n = width_of(m);
      r = 32'd0;
      for (int i = 31; i >= 0; i--) begin
         b = d[i] ^ r[n-1];
         r = ((r << 1) & m) ^ (b ? (p & m) : 32'd0);
      end
      for (int i = n - 1; i >= 0; i--) begin
         b = c[i] ^ r[n-1];
         r = ((r << 1) & m) ^ (b ? (p & m) : 32'd0);
      end
      return r;
   endfunction

   // Track the registered polynomial/mask the DUT should currently hold
   always @(posedge clk) begin
      if (!rst_n) begin
         m_poly <= 32'd0;
         m_mask <= 32'd0;
      end else begin
         m_poly <= crc_poly;
         m_mask <= crc_poly_size;
      end
   end

   // Compare process: model every cycle, plus literal and residue checks
   always @(negedge clk) begin
      if (chk_on) begin
         exp_crc = model_crc(data_in, crc_in, m_poly, m_mask);
         total++;
         if (crc_out !== exp_crc) begin
            bad++;
            $display("FAIL model: data=%h seed=%h poly=%h mask=%h crc_out=%h expected=%h",
                     data_in, crc_in, m_poly, m_mask, crc_out, exp_crc);
         end
         if (lit_on) begin
            total++;
            if (crc_out !== lit_exp) begin
               bad++;
               $display("FAIL %s: crc_out=%h expected=%h", lit_name, crc_out, lit_exp);
            end
         end
         if (m_mask != 32'd0 && (crc_in & m_mask) == 32'd0) begin
            res = residue(data_in, crc_out, m_poly, m_mask);
            total++;
            if (res !== 32'd0) begin
               bad++;
               $display("FAIL residue: data=%h crc_out=%h residue=%h expected=00000000",
                        data_in, crc_out, res);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_now(input string name, input logic [31:0] exp);
      lit_name = name;
      lit_exp  = exp;
      lit_on   = 1'b1;
      @(negedge clk);
      #1;
      lit_on   = 1'b0;
      tick();
   endtask

   task automatic set_poly(input logic [31:0] p, input logic [31:0] m);
      crc_poly      = p;
      crc_poly_size = m;
      tick();
   endtask

   logic [31:0] polys [3] = '{32'h0000_0007, 32'h0000_8005, 32'h04C1_1DB7};
   logic [31:0] masks [3] = '{32'h0000_00FF, 32'h0000_FFFF, 32'hFFFF_FFFF};

   initial begin
      rst_n         = 1'b0;
      data_in       = 32'hFFFF_FFFF;
      crc_in        = 32'hFFFF_FFFF;
      crc_poly      = 32'h0000_0007;
      crc_poly_size = 32'h0000_00FF;

      tick();
      chk_on = 1'b1;
      expect_now("reset_1", 32'h0000_0000);
      expect_now("reset_2", 32'h0000_0000);

      rst_n   = 1'b1;
      data_in = 32'd0;
      crc_in  = 32'd0;
      tick();
      data_in = 32'h0000_0001; expect_now("crc8_d1", 32'h0000_0007);
      data_in = 32'h0000_0002; expect_now("crc8_d2", 32'h0000_000E);
      data_in = 32'h0000_0000; expect_now("crc8_d0", 32'h0000_0000);
      crc_in  = 32'h0000_0001; expect_now("crc8_seed", 32'h0000_0016);

      crc_in  = 32'd0;
      set_poly(32'h04C1_1DB7, 32'hFFFF_FFFF);
      data_in = 32'h0000_0001; expect_now("crc32_d1", 32'h04C1_1DB7);

      set_poly(32'hFFFF_FF05, 32'h0000_001F);
      data_in = 32'h0000_0001;
      crc_in  = 32'hFFFF_FFE0; expect_now("crc5_mask", 32'h0000_0005);

      crc_in  = 32'd0;
      set_poly(32'h0000_0007, 32'h0000_00FF);
      data_in       = 32'h0000_0001;
      crc_poly      = 32'h04C1_1DB7;
      crc_poly_size = 32'hFFFF_FFFF;
      lit_name = "latency_before";
      lit_exp  = 32'h0000_0007;
      lit_on   = 1'b1;
      @(negedge clk);
      #1;
      lit_on   = 1'b0;
      tick();
      expect_now("latency_after", 32'h04C1_1DB7);

      for (int p = 0; p < 3; p++) begin
         crc_in = 32'd0;
         set_poly(polys[p], masks[p]);
         for (int k = 0; k < 100; k++) begin
            data_in = $urandom;
            tick();
         end
      end

      for (int k = 0; k < 20; k++) begin
         data_in = $urandom;
         crc_in  = $urandom;
         tick();
      end

      rst_n   = 1'b0;
      tick();
      data_in = 32'h1234_5678;
      crc_in  = 32'hDEAD_BEEF;
      expect_now("reset_mid", 32'h0000_0000);

      chk_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/crc_parallel.md
Name: crc_parallel

Overview:
- Single-cycle, fully unrolled, run-time programmable CRC generator. It computes the CRC of one FRAME_SIZE-bit data word per clock.
- Polynomial and active width are programmable up to CRC_SIZE bits and are captured in registers. Data and initial value are combinational inputs.
- Used as the parallel counterpart of the serial CRC engine. Its output is the check field appended to a frame to form a code word {data, crc}.

Parameters:
- CRC_SIZE, 32, maximum CRC width in bits (the register width).
- FRAME_SIZE, 32, data word width processed per evaluation.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active low.
- data_in  input  FRAME_SIZE  message word; bit FRAME_SIZE-1 is processed first.
- crc_in  input  CRC_SIZE  initial CRC register value (seed or running CRC).
- crc_poly  input  CRC_SIZE  generator polynomial coefficients x^(n-1)..x^0, without the implicit leading x^n term; LSB = x^0.
- crc_poly_size  input  CRC_SIZE  active-width mask. Thermometer code from the LSB: n ones select CRC degree n (e.g. 0x000000FF = CRC-8).
- crc_out  output  CRC_SIZE  computed CRC, right-aligned; bits at or above n are 0.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- State: poly_q[CRC_SIZE-1:0] and mask_q[CRC_SIZE-1:0].
  - On every rising clk with rst_n=1: poly_q <= crc_poly, mask_q <= crc_poly_size. There is no enable.
  - On a rising clk with rst_n=0: poly_q <= 0, mask_q <= 0.
- Latency:
  - Changes on crc_poly / crc_poly_size take effect one clock after they are sampled.
  - crc_out responds combinationally (zero latency) to data_in and crc_in.
- Computation is combinational, equivalent to FRAME_SIZE unrolled serial LFSR steps:
  - start: r = crc_in & mask_q.
  - top = mask_q & ~(mask_q >> 1), a one-hot select of the MSB of the active width.
  - for i = FRAME_SIZE-1 down to 0: fb = data_in[i] XOR |(r & top); r = ((r << 1) & mask_q) XOR (fb ? (poly_q & mask_q) : 0).
  - crc_out = r.
- Algebraically: crc_out = (crc_in·x^FRAME_SIZE + D(x)·x^n) mod P(x), where P = x^n + crc_poly.
- Conventions: non-reflected input and output, no final XOR. With crc_in = 0, the code word {data_in, crc_out} is divisible by P.
- Reset and masking:
  - During and after reset, until the mask is loaded, mask_q = 0 forces crc_out = 0 for any data_in / crc_in.
  - crc_in bits above the active width are ignored.
  - crc_poly bits above the active width are ignored.
- Non-thermometer masks are unsupported; the result is undefined but must not produce X from known inputs.
- No storage of data; no handshake; crc_out is valid whenever inputs are stable.
- Implementation: a generate/for loop over FRAME_SIZE steps, with the two registers in one always block.

Test Plan:
1. Reset: rst_n=0 for 2 clocks, data_in=0xFFFFFFFF, crc_in=0xFFFFFFFF -> crc_out=0x00000000.
2. Basic CRC-8 and CRC-32, crc_in=0:
   - CRC-8: load crc_poly=0x07, crc_poly_size=0x000000FF, wait 1 clock. data_in=0x00000001 -> crc_out=0x00000007; data_in=0x00000002 -> 0x0000000E; data_in=0 -> 0.
   - CRC-32: crc_poly=0x04C11DB7, crc_poly_size=0xFFFFFFFF. data_in=0x00000001 -> crc_out=0x04C11DB7.
3. Seed propagation: CRC-8 setup, data_in=0, crc_in=0x00000001 -> crc_out=0x00000016 (x^32 mod x^8+x^2+x+1).
4. Narrow width / masking:
   - crc_poly=0xFFFFFF05, crc_poly_size=0x0000001F (CRC-5, x^5+x^2+1), data_in=1, crc_in=0xFFFFFFE0 -> crc_out=0x00000005.
   - Upper poly bits and upper crc_in bits are ignored in this case.
5. Poly-change latency:
   - From CRC-8 state, change crc_poly to 0x04C11DB7 and crc_poly_size to 0xFFFFFFFF with data_in=1. Before the next edge, crc_out=0x07; after the edge, crc_out=0x04C11DB7.
6. Code-word check: for 100 random data words per polynomial (CRC-8, CRC-16 0x8005, CRC-32), crc_out must equal a bit-serial reference model, and the serial LFSR run over {data_in, crc_out} must leave residue 0.
